// File: rtl/rng_arbiter.sv
// rng_arbiter: shares one free-running RNG among NUM_REQ requesters.
// A round-robin arbiter picks a requester, then rejection-samples rng_rand
// against that requester's exclusive upper bound. The bound is latched at
// grant time. The transaction completes with a one-cycle one-hot ack, or with
// fail after MAX_TRIES rejected samples.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   rng_rand   free-running random word
//   req        level request per requester, held until its ack
//   req_bound  packed per-requester exclusive bound (0 = accept anything)
//   ack        one-hot completion pulse, one cycle
//   rand_out   accepted value (0 on fail), held until the next completion
//   fail       completion without an accepted value
//   busy       transaction in progress (SAMPLE or DONE)
module rng_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           rng_rand,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_bound,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           rand_out,
  output logic                       fail,
  output logic                       busy
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     gid_q, gid_d;
  logic [GW-1:0]     last_q, last_d;
  logic [WIDTH-1:0]  bound_q, bound_d;
  logic [TW-1:0]     try_q, try_d;
  logic [NUM_REQ-1:0] ack_d;
  logic [WIDTH-1:0]  rand_d;
  logic              fail_d;
  logic              busy_d;

  logic              pick_vld;
  logic [GW-1:0]     pick_idx;
  logic [WIDTH-1:0]  bounds [NUM_REQ];

  // Unpack the flat bound bus into one word per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bounds
    assign bounds[i] = req_bound[WIDTH*i +: WIDTH];
  end

  // Round-robin pick: scan last+1 .. last+NUM_REQ with wrap; the loop runs
  // farthest-first so the nearest active requester is the one that sticks.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (req[GW'(idx)]) begin
        pick_vld = 1'b1;
        pick_idx = GW'(idx);
      end
    end
  end

  // State register plus the registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gid_q    <= '0;
      last_q   <= GW'(NUM_REQ - 1);
      bound_q  <= '0;
      try_q    <= '0;
      ack      <= '0;
      rand_out <= '0;
      fail     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
      bound_q  <= bound_d;
      try_q    <= try_d;
      ack      <= ack_d;
      rand_out <= rand_d;
      fail     <= fail_d;
      busy     <= busy_d;
    end
  end

  // Next-state and next-output logic; ack is raised on the edge that enters
  // DONE so it is high exactly for the DONE cycle.
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    last_d  = last_q;
    bound_d = bound_q;
    try_d   = try_q;
    ack_d   = '0;
    rand_d  = rand_out;
    fail_d  = fail;

    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gid_d   = pick_idx;
          bound_d = bounds[pick_idx];
          try_d   = '0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (!req[gid_q]) begin
          // Requester withdrew: drop quietly, but still rotate priority.
          last_d  = gid_q;
          state_d = IDLE;
        end else if ((bound_q == '0) || (rng_rand < bound_q)) begin
          rand_d        = rng_rand;
          fail_d        = 1'b0;
          ack_d[gid_q]  = 1'b1;
          state_d       = DONE;
        end else if (try_q == TW'(MAX_TRIES - 1)) begin
          rand_d        = '0;
          fail_d        = 1'b1;
          ack_d[gid_q]  = 1'b1;
          state_d       = DONE;
        end else begin
          try_d = try_q + TW'(1);
        end
      end
      DONE: begin
        last_d  = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed bench for rng_arbiter (NUM_REQ=4, WIDTH=12, MAX_TRIES=16).
module tb_rng_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rng_rand;
  logic [3:0]  req;
  logic [47:0] req_bound;
  logic [3:0]  ack;
  logic [11:0] rand_out;
  logic        fail;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rng_arbiter #(.NUM_REQ(4), .WIDTH(12), .MAX_TRIES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rng_rand  (rng_rand),
    .req       (req),
    .req_bound (req_bound),
    .ack       (ack),
    .rand_out  (rand_out),
    .fail      (fail),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  req;
    logic [47:0] bound;
    logic [11:0] rng;
    logic [3:0]  ack;
    logic [11:0] rnd;
    logic        fail;
    int          lat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance edges until ack is seen or the budget runs out; n counts edges.
  task automatic wait_ack(input int start, input int limit, output int n);
    n = start;
    while (n < limit) begin
      tick();
      n++;
      if (ack != 4'd0) break;
    end
  endtask

  initial begin
    int n;
    int last_n;
    int got;
    logic [3:0] order [5];

    tbl[0] = '{"accept",     4'b0001, {12'd0, 12'd0, 12'd0, 12'd100},  12'd42,   4'b0001, 12'd42,   1'b0, 2};
    tbl[1] = '{"bound0",     4'b1000, {12'd0, 12'd0, 12'd0, 12'd0},    12'd4095, 4'b1000, 12'd4095, 1'b0, 2};
    tbl[2] = '{"exhaust",    4'b0100, {12'd0, 12'd1, 12'd0, 12'd0},    12'd5,    4'b0100, 12'd0,    1'b1, 17};
    tbl[3] = '{"bound1_z",   4'b0010, {12'd0, 12'd0, 12'd1, 12'd0},    12'd0,    4'b0010, 12'd0,    1'b0, 2};
    tbl[4] = '{"below_max",  4'b0001, {12'd0, 12'd0, 12'd0, 12'd4095}, 12'd4094, 4'b0001, 12'd4094, 1'b0, 2};
    tbl[5] = '{"equal_rej",  4'b0001, {12'd0, 12'd0, 12'd0, 12'd4095}, 12'd4095, 4'b0001, 12'd0,    1'b1, 17};

    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    // Reset with a request pending: nothing may be granted while held.
    rst_n = 1'b0; req = 4'b1111; req_bound = '0; rng_rand = 12'd7;
    #2;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rand", 32'(rand_out), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req = 4'b0000;
    tick(); tick();
    chk("rst_hold_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;

    // Fairness: all four requesting, bound 0; ack 1,2,4,8,1 every 3 clk.
    req = 4'b1111; req_bound = '0; rng_rand = 12'd123;
    n = 0; last_n = 0; got = 0;
    while (n < 40 && got < 5) begin
      tick();
      n++;
      if (ack != 4'd0) begin
        chk($sformatf("fair_ack%0d", got), 32'(ack), 32'(order[got]));
        if (got == 0) chk("fair_first_lat", 32'(n), 32'd2);
        else          chk($sformatf("fair_gap%0d", got), 32'(n - last_n), 32'd3);
        last_n = n;
        got++;
      end
    end
    chk("fair_count", 32'(got), 32'd5);
    req = 4'b0000;
    tick(); tick();

    // Single-transaction vectors with constant rng_rand.
    for (int i = 0; i < 6; i++) begin
      req = tbl[i].req; req_bound = tbl[i].bound; rng_rand = tbl[i].rng;
      wait_ack(0, 40, n);
      chk({tbl[i].name, "_lat"},  32'(n),        32'(tbl[i].lat));
      chk({tbl[i].name, "_ack"},  32'(ack),      32'(tbl[i].ack));
      chk({tbl[i].name, "_rand"}, 32'(rand_out), 32'(tbl[i].rnd));
      chk({tbl[i].name, "_fail"}, 32'(fail),     32'(tbl[i].fail));
      chk({tbl[i].name, "_busy"}, 32'(busy),     32'd1);
      req = 4'b0000;
      tick();
      chk({tbl[i].name, "_ack_clr"},  32'(ack),  32'd0);
      chk({tbl[i].name, "_busy_clr"}, 32'(busy), 32'd0);
      chk({tbl[i].name, "_hold"},     32'(rand_out), 32'(tbl[i].rnd));
    end

    // Rejection sequence 500, 20, 7 against bound 10; the bound is cleared
    // right after the grant and must not affect the running transaction.
    req = 4'b0010; req_bound = {12'd0, 12'd0, 12'd10, 12'd0}; rng_rand = 12'd500;
    tick();                 // E0: grant
    req_bound = '0;
    tick();                 // E1: 500 rejected
    chk("rej_e1_ack", 32'(ack), 32'd0);
    rng_rand = 12'd20;
    tick();                 // E2: 20 rejected
    chk("rej_e2_ack", 32'(ack), 32'd0);
    rng_rand = 12'd7;
    tick();                 // E3: 7 accepted
    chk("rej_ack", 32'(ack), 32'b0010);
    chk("rej_rand", 32'(rand_out), 32'd7);
    chk("rej_fail", 32'(fail), 32'd0);
    req = 4'b0000;
    tick();

    // Abort: requester 0 (always rejecting) drops its request in SAMPLE;
    // requester 1 must be served next and requester 0 never acked.
    req = 4'b0011; req_bound = {12'd0, 12'd0, 12'd0, 12'd1}; rng_rand = 12'd5;
    tick();                 // grant 0
    tick();                 // reject
    chk("abort_pre_ack", 32'(ack), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    req = 4'b0010;
    wait_ack(2, 40, n);
    chk("abort_lat", 32'(n), 32'd5);
    chk("abort_ack", 32'(ack), 32'b0010);
    chk("abort_rand", 32'(rand_out), 32'd5);
    req = 4'b0000;
    tick();

    // Reset in SAMPLE: outputs clear at once, then requester 0 goes first.
    req = 4'b0100; req_bound = {12'd0, 12'd1, 12'd0, 12'd0}; rng_rand = 12'd5;
    tick(); tick(); tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_rand", 32'(rand_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_fail", 32'(fail), 32'd0);
    req = 4'b1111; req_bound = '0; rng_rand = 12'd9;
    tick();
    chk("mid_rst_hold", 32'(ack), 32'd0);
    rst_n = 1'b1;
    wait_ack(0, 40, n);
    chk("post_rst_lat", 32'(n), 32'd2);
    chk("post_rst_ack", 32'(ack), 32'b0001);
    chk("post_rst_rand", 32'(rand_out), 32'd9);
    req = 4'b0000;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
